// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: controller states, control bundle,
// special register numbers and opcodes used across the pipeline.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [4:0]  REG_RA    = 5'd31;
  localparam logic [5:0]  OP_LW     = 6'b100011;
  localparam logic [5:0]  OP_JAL    = 6'b000011;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE  = ctrl_t'(5'b00000);
  localparam ctrl_t CTRL_LU    = ctrl_t'(5'b11010);
  localparam ctrl_t CTRL_REDIR = ctrl_t'(5'b00111);
  localparam ctrl_t CTRL_DRAIN = ctrl_t'(5'b10100);
  localparam ctrl_t CTRL_DONE  = ctrl_t'(5'b11011);

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                q <= '0;
    else if (clr)              q <= '0;
    else if (inc && q != '1)   q <= q + 1'b1;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: load-use
// stalls, redirect flushes, halt drain sequencing and perf counters.
module pipeline_controller
  import mips_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_wb_addr,
  input  logic             mem_branch_taken,
  input  logic             mem_jump,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       done_q;
  ctrl_t      ctrl;
  logic       redirect, lu, inc_stall, inc_flush;

  assign redirect = mem_branch_taken | mem_jump;

  // $zero is never a real producer, so it cannot create a hazard
  assign lu = id_valid & ex_mem_to_reg & ex_reg_write & (ex_wb_addr != REG_ZERO) &
              ((id_uses_rs & (id_rs_addr == ex_wb_addr)) |
               (id_uses_rt & (id_rt_addr == ex_wb_addr)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    ctrl      = CTRL_NONE;
    state_d   = state_q;
    drain_d   = drain_q;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          ctrl      = CTRL_REDIR;
          inc_flush = 1'b1;
        end else if (lu) begin
          ctrl      = CTRL_LU;
          inc_stall = 1'b1;
        end else if (id_valid && id_halt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        // a redirect here means the halt itself was on a wrong path
        if (redirect) begin
          ctrl      = CTRL_REDIR;
          inc_flush = 1'b1;
          state_d   = ST_RUN;
          drain_d   = '0;
        end else begin
          ctrl = CTRL_DRAIN;
          if (drain_q == '0) state_d = ST_DONE;
          else               drain_d = drain_q - 1'b1;
        end
      end
      ST_DONE: ctrl = CTRL_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // controls stay quiet for the whole reset window, independent of inputs
  assign stall_pc    = RST_N & ctrl.stall_pc;
  assign stall_ifid  = RST_N & ctrl.stall_ifid;
  assign flush_ifid  = RST_N & ctrl.flush_ifid;
  assign flush_idex  = RST_N & ctrl.flush_idex;
  assign flush_exmem = RST_N & ctrl.flush_exmem;
  assign done        = done_q;
  assign state       = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (inc_stall),
    .clr   (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (inc_flush),
    .clr   (1'b0),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: vector table plus drain,
// wrong-path, async-reset and saturation sequences with a counter scoreboard.
module tb_pipeline_controller;
  import mips_pkg::*;

  localparam int CW = 4;
  localparam int DC = 4;
  localparam logic [4:0] C0  = 5'b00000;
  localparam logic [4:0] CLU = 5'b11010;
  localparam logic [4:0] CRD = 5'b00111;
  localparam logic [4:0] CDR = 5'b10100;
  localparam logic [4:0] CDN = 5'b11011;

  logic CLK = 1'b0, RST_N = 1'b0;
  logic id_valid, id_uses_rs, id_uses_rt, id_halt, ex_mem_to_reg, ex_reg_write;
  logic mem_branch_taken, mem_jump;
  logic [4:0] id_rs_addr, id_rt_addr, ex_wb_addr;
  logic stall_pc, stall_ifid, flush_ifid, flush_idex, flush_exmem, done;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [4:0] ctrl_act;

  assign ctrl_act = {stall_pc, stall_ifid, flush_ifid, flush_idex, flush_exmem};

  always #5 CLK = ~CLK;

  pipeline_controller #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_wb_addr(ex_wb_addr),
    .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .flush_exmem(flush_exmem), .done(done), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic v; logic [4:0] rs, rt; logic urs, urt, halt, m2r, rw;
    logic [4:0] wb; logic br, jmp; logic [4:0] exp;
  } vec_t;
  typedef struct { string nm; int stall; int flush; int st; int dn; } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   tests = 0, fails = 0;
  int   m_stall = 0, m_flush = 0;
  int   sat_max = (1 << CW) - 1;

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic halt, logic m2r, logic rw, logic [4:0] wb,
                              logic br, logic jmp, logic [4:0] exp);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.halt = halt;
    x.m2r = m2r; x.rw = rw; x.wb = wb; x.br = br; x.jmp = jmp; x.exp = exp;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t x);
    id_valid = x.v; id_rs_addr = x.rs; id_rt_addr = x.rt; id_uses_rs = x.urs;
    id_uses_rt = x.urt; id_halt = x.halt; ex_mem_to_reg = x.m2r; ex_reg_write = x.rw;
    ex_wb_addr = x.wb; mem_branch_taken = x.br; mem_jump = x.jmp;
  endtask

  task automatic idle();
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0));
  endtask

  // entered right after a negedge with inputs already driven
  task automatic cycle(input string nm, input logic [4:0] exp, input int nst, input int ndn);
    sb_t e;
    #2;
    chk({nm, " ctrl"}, int'(ctrl_act), int'(exp));
    if (exp == CLU && m_stall < sat_max) m_stall++;
    if (exp == CRD && m_flush < sat_max) m_flush++;
    sbq.push_back('{nm, m_stall, m_flush, nst, ndn});
    @(posedge CLK); #1;
    e = sbq.pop_front();
    chk({e.nm, " stall_cnt"}, int'(stall_cnt), e.stall);
    chk({e.nm, " flush_cnt"}, int'(flush_cnt), e.flush);
    chk({e.nm, " state"}, int'(state), e.st);
    chk({e.nm, " done"}, int'(done), e.dn);
    @(negedge CLK);
  endtask

  task automatic reset_check(input string nm);
    #1;
    chk({nm, " ctrl"}, int'(ctrl_act), 0);
    chk({nm, " state"}, int'(state), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " stall_cnt"}, int'(stall_cnt), 0);
    chk({nm, " flush_cnt"}, int'(flush_cnt), 0);
    m_stall = 0;
    m_flush = 0;
  endtask

  vec_t lu_rs, halt_v;

  initial begin
    lu_rs  = mk(1, 8, 3, 1, 1, 0, 1, 1, 8, 0, 0, CLU);
    halt_v = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C0);
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0));   // idle
    vecs.push_back(lu_rs);                                     // lu on rs
    vecs.push_back(mk(1, 2, 9, 1, 1, 0, 1, 1, 9, 0, 0, CLU));  // lu on rt
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, C0));   // $zero producer
    vecs.push_back(mk(1, 2, 9, 1, 0, 0, 1, 1, 9, 0, 0, C0));   // rt match unused
    vecs.push_back(mk(1, 8, 3, 1, 1, 0, 0, 1, 8, 0, 0, C0));   // not a load
    vecs.push_back(mk(1, 8, 3, 1, 1, 0, 1, 0, 8, 0, 0, C0));   // no reg write
    vecs.push_back(mk(0, 8, 3, 1, 1, 0, 1, 1, 8, 0, 0, C0));   // ID bubble
    vecs.push_back(mk(1, 8, 3, 1, 1, 0, 1, 1, 8, 1, 0, CRD));  // branch beats lu
    vecs.push_back(mk(1, 8, 3, 1, 1, 0, 1, 1, 8, 0, 1, CRD));  // jump beats lu
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, CRD));  // jump beats halt
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C0));   // halt in bubble
    vecs.push_back(mk(1, 31, 31, 1, 1, 0, 1, 1, 31, 0, 0, CLU)); // both match

    // reset window: hazard inputs present, controls must stay low
    set_in(lu_rs);
    mem_branch_taken = 1'b1;
    #3;
    reset_check("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    idle();

    foreach (vecs[i]) begin
      set_in(vecs[i]);
      cycle($sformatf("vec%0d", i), vecs[i].exp, 0, 0);
    end

    // halt drain then frozen DONE
    set_in(halt_v);
    cycle("halt accept", C0, 1, 0);
    idle();
    for (int i = 0; i < DC; i++)
      cycle($sformatf("drain%0d", i), CDR, (i == DC - 1) ? 2 : 1, (i == DC - 1) ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      set_in(lu_rs);
      mem_branch_taken = i[0];
      mem_jump = ~i[0];
      cycle($sformatf("done%0d", i), CDN, 2, 1);
    end
    #2 RST_N = 1'b0;
    reset_check("reset from done");
    @(negedge CLK);
    RST_N = 1'b1;
    idle();

    // wrong-path halt
    set_in(halt_v);
    cycle("wp accept", C0, 1, 0);
    idle();
    cycle("wp drain1", CDR, 1, 0);
    mem_jump = 1'b1;
    cycle("wp redirect", CRD, 0, 0);
    idle();
    cycle("wp after", C0, 0, 0);

    // async reset in the middle of DRAIN
    set_in(halt_v);
    cycle("ar accept", C0, 1, 0);
    idle();
    cycle("ar drain1", CDR, 1, 0);
    set_in(lu_rs);
    #2 RST_N = 1'b0;
    reset_check("reset mid-drain");
    @(negedge CLK);
    RST_N = 1'b1;
    idle();
    cycle("post reset", C0, 0, 0);

    // counter saturation
    set_in(lu_rs);
    for (int i = 0; i < (1 << CW) + 3; i++) cycle($sformatf("sat stall%0d", i), CLU, 0, 0);
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CRD));
    for (int i = 0; i < (1 << CW) + 3; i++) cycle($sformatf("sat flush%0d", i), CRD, 0, 0);
    idle();
    cycle("sat hold", C0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards between the ID and EX stages and generates stall and bubble controls for the PC, IF/ID and ID/EX registers.
- Flushes wrong-path instructions when a branch or jump resolves taken in MEM.
- Sequences end-of-program: halt detect, pipeline drain, then done. Keeps saturating stall and flush performance counters.

Parameters:
- DRAIN_CYCLES, 4: cycles spent in DRAIN after a halt is accepted; range 1..15.
- CNT_W, 16: width of each performance counter.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_rs_addr  in  5  rs field of the ID instruction.
- id_rt_addr  in  5  rt field of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_halt  in  1  ID instruction is the halt word 32'hFFFFFFFF.
- ex_mem_to_reg  in  1  EX instruction is a load (MemtoRegE).
- ex_reg_write  in  1  EX instruction writes the register file (RegWriteE).
- ex_wb_addr  in  5  EX write-back address (wb_addr_out).
- mem_branch_taken  in  1  branch resolved taken in MEM.
- mem_jump  in  1  j, jal or jr in MEM.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold the IF/ID register.
- flush_ifid  out  1  load a bubble into IF/ID.
- flush_idex  out  1  load a bubble into ID/EX (all control signals 0).
- flush_exmem  out  1  load a bubble into EX/MEM.
- done  out  1  program finished; registered.
- state  out  2  0=RUN, 1=DRAIN, 2=DONE.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of redirect flush events.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=RUN, done=0, drain counter=0, stall_cnt=0, flush_cnt=0.
  - All stall and flush outputs are forced 0 while reset is asserted.
- Control outputs are combinational from current inputs and registered state, with zero latency, so they take effect at the next CLK edge.
- redirect = mem_branch_taken | mem_jump.
- Load-use hazard (lu):
  - lu = id_valid & ex_mem_to_reg & ex_reg_write & (ex_wb_addr != 0) & ((id_uses_rs & id_rs_addr == ex_wb_addr) | (id_uses_rt & id_rt_addr == ex_wb_addr)).
- RUN state:
  - If redirect: flush_ifid=1, flush_idex=1, flush_exmem=1, all stalls=0, flush_cnt+1. Redirect has priority over lu and halt.
  - Else if lu: stall_pc=1, stall_ifid=1, flush_idex=1, stall_cnt+1. Exactly one stall cycle per load, because the next cycle EX holds a bubble.
  - Else if id_valid & id_halt: at the edge go to DRAIN, drain counter=DRAIN_CYCLES-1. No stall outputs in the accept cycle.
- DRAIN state:
  - stall_pc=1, flush_ifid=1; the halt is propagating and older instructions retire.
  - Counter decrements each cycle. At counter==0, go to DONE at the next edge.
  - If redirect occurs in DRAIN (the halt was on a wrong path): apply the RUN redirect outputs, return to RUN, clear the counter, flush_cnt+1.
- DONE state:
  - stall_pc=1, stall_ifid=1, flush_idex=1, flush_exmem=1; the pipeline stays frozen with bubbles downstream.
  - done=1 from the edge that enters DONE. Only reset exits DONE.
  - lu and redirect are ignored; counters freeze.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-DRAIN aborts immediately to RUN with all values at reset state.
- ex_wb_addr==0 never causes a stall ($zero).

Decomposition:
- Shared package mips_pkg:
  - state encodings ST_RUN, ST_DRAIN, ST_DONE.
  - HALT_WORD=32'hFFFFFFFF.
  - REG_ZERO=5'd0, REG_RA=5'd31.
  - Opcodes OP_LW, OP_JAL (shared with the decode and EX logic).
- One natural sub-module, sat_counter (parameter W; ports inc, clr, q), instantiated twice for stall_cnt and flush_cnt.
- The hazard comparator and FSM stay in the top module.

Test Plan:
- Load-use on rs: EX lw to $8 (ex_mem_to_reg=1, ex_reg_write=1, ex_wb_addr=8); ID add with rs=8, id_uses_rs=1 -> stall_pc=stall_ifid=flush_idex=1 for exactly 1 cycle; stall_cnt 0->1.
- No stall on $zero or unused operand: ex_wb_addr=0, or rt match with id_uses_rt=0 -> all controls 0, stall_cnt unchanged.
- Redirect beats hazard: lu conditions true and mem_branch_taken=1 in the same cycle -> flush_ifid=flush_idex=flush_exmem=1, stall_pc=0; flush_cnt+1; stall_cnt unchanged.
- Halt drain with DRAIN_CYCLES=4: id_halt=1, id_valid=1 at cycle t -> state=DRAIN for cycles t+1..t+4, state=DONE and done=1 from t+5; during DONE, lu/redirect toggling changes nothing.
- Wrong-path halt: enter DRAIN, then mem_jump=1 on the 2nd DRAIN cycle -> 3 flush outputs high that cycle, state=RUN next cycle, done stays 0.
- Async reset mid-DRAIN: drop RST_N between clock edges -> state=0, done=0, all controls 0 immediately; counters 0. Separately, force 2^CNT_W+3 stalls -> stall_cnt holds at all-ones.
